// File: rtl/controle_jogo.sv
// Game-level sequencer: owns the attract/serve/play/pause/lost/game-over flow,
// the shared ship/ball control lines, the movement tick and the lives/score counters.
module controle_jogo #(
    parameter int TICK_DIV       = 416667,
    parameter int LOST_CYCLES    = 50000000,
    parameter int VIDAS_INICIAIS = 3
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [3:0]  keysout,
    input  logic        bola_perdida,
    input  logic        bloco_destruido,
    output logic        pausa,
    output logic        reiniciarJogo,
    output logic        iniciarBola,
    output logic        game_tick,
    output logic [2:0]  vidas,
    output logic [15:0] pontos,
    output logic [2:0]  estado
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        PAUSE     = 3'd3,
        LOST      = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LOST_W = (LOST_CYCLES > 1) ? $clog2(LOST_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [LOST_W-1:0] LOST_LAST  = LOST_W'(LOST_CYCLES - 1);
    localparam logic [2:0]        VIDAS_INIT = 3'(VIDAS_INICIAIS);

    state_t state, next_state;
    state_t ret_state, next_ret;

    logic [1:0] key_q1, key_q2, key_armed;
    logic       start_ev, pause_ev;
    logic       unused_keys;

    logic              next_pausa, next_rein, next_bola, clear_tick;
    logic [2:0]        next_vidas;
    logic [15:0]       next_pontos;
    logic [LOST_W-1:0] lost_cnt, next_lost;
    logic [TICK_W-1:0] tick_cnt;

    assign unused_keys = ^keysout[1:0];

    // A key only counts once it has been seen released since reset, so a key
    // held through reset release does not fire a spurious event.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_q1    <= 2'b00;
            key_q2    <= 2'b00;
            key_armed <= 2'b00;
        end else begin
            key_q1    <= keysout[3:2];
            key_q2    <= key_q1;
            key_armed <= key_armed | ~keysout[3:2];
        end
    end

    assign start_ev = key_q1[0] & ~key_q2[0] & key_armed[0];
    assign pause_ev = key_q1[1] & ~key_q2[1] & key_armed[1];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state         <= IDLE;
            ret_state     <= IDLE;
            pausa         <= 1'b1;
            reiniciarJogo <= 1'b0;
            iniciarBola   <= 1'b0;
            vidas         <= VIDAS_INIT;
            pontos        <= 16'd0;
            lost_cnt      <= '0;
        end else begin
            state         <= next_state;
            ret_state     <= next_ret;
            pausa         <= next_pausa;
            reiniciarJogo <= next_rein;
            iniciarBola   <= next_bola;
            vidas         <= next_vidas;
            pontos        <= next_pontos;
            lost_cnt      <= next_lost;
        end
    end

    always_comb begin
        next_state  = state;
        next_ret    = ret_state;
        next_rein   = 1'b0;
        next_bola   = iniciarBola;
        next_vidas  = vidas;
        next_pontos = pontos;
        next_lost   = lost_cnt;
        clear_tick  = 1'b0;

        case (state)
            IDLE, GAME_OVER: begin
                if (start_ev) begin
                    next_state  = SERVE;
                    next_rein   = 1'b1;
                    next_bola   = 1'b0;
                    next_vidas  = VIDAS_INIT;
                    next_pontos = 16'd0;
                    clear_tick  = 1'b1;
                end
            end
            SERVE: begin
                if (pause_ev) begin
                    next_state = PAUSE;
                    next_ret   = SERVE;
                end else if (start_ev) begin
                    next_state = PLAY;
                    next_bola  = 1'b1;
                end
            end
            PLAY: begin
                // A brick hit in the same cycle as a lost ball still scores.
                if (bloco_destruido) begin
                    next_pontos = pontos + 16'd1;
                end
                if (bola_perdida) begin
                    next_state = LOST;
                    next_bola  = 1'b0;
                    next_vidas = (vidas == 3'd0) ? 3'd0 : vidas - 3'd1;
                    next_lost  = '0;
                end else if (pause_ev) begin
                    next_state = PAUSE;
                    next_ret   = PLAY;
                end
            end
            PAUSE: begin
                if (pause_ev) begin
                    next_state = ret_state;
                end
            end
            LOST: begin
                if (lost_cnt == LOST_LAST) begin
                    next_state = (vidas == 3'd0) ? GAME_OVER : SERVE;
                end else begin
                    next_lost = lost_cnt + LOST_W'(1);
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        next_pausa = (next_state == IDLE) || (next_state == PAUSE) ||
                     (next_state == LOST) || (next_state == GAME_OVER);
    end

    // Divider advances on unpaused cycles only and keeps its phase across a pause.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            tick_cnt  <= '0;
            game_tick <= 1'b0;
        end else if (clear_tick) begin
            tick_cnt  <= '0;
            game_tick <= 1'b0;
        end else if (!pausa) begin
            if (tick_cnt == TICK_LAST) begin
                tick_cnt  <= '0;
                game_tick <= 1'b1;
            end else begin
                tick_cnt  <= tick_cnt + TICK_W'(1);
                game_tick <= 1'b0;
            end
        end else begin
            game_tick <= 1'b0;
        end
    end

    assign estado = state;

endmodule

// File: tb/tb_controle_jogo.sv
// Bench for controle_jogo: directed vector table, hand-written tick/pause sequence,
// then randomized stimulus against a rule-level reference model.
module tb_controle_jogo;

    localparam int TICK_DIV       = 4;
    localparam int LOST_CYCLES    = 8;
    localparam int VIDAS_INICIAIS = 2;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  keysout = 4'd0;
    logic        bola_perdida = 1'b0;
    logic        bloco_destruido = 1'b0;
    logic        pausa, reiniciarJogo, iniciarBola, game_tick;
    logic [2:0]  vidas;
    logic [15:0] pontos;
    logic [2:0]  estado;

    int vectors = 0;
    int miscompares = 0;

    controle_jogo #(
        .TICK_DIV(TICK_DIV),
        .LOST_CYCLES(LOST_CYCLES),
        .VIDAS_INICIAIS(VIDAS_INICIAIS)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .keysout(keysout),
        .bola_perdida(bola_perdida),
        .bloco_destruido(bloco_destruido),
        .pausa(pausa),
        .reiniciarJogo(reiniciarJogo),
        .iniciarBola(iniciarBola),
        .game_tick(game_tick),
        .vidas(vidas),
        .pontos(pontos),
        .estado(estado)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference model: game rules expressed with plain integers.
    int m_state, m_ret, m_bola, m_vidas, m_pontos, m_lost_seen;
    int m_unpaused, m_tick, m_rein, m_pausa;
    bit m_last[2], m_seen_low[2], m_pending[2];

    task automatic modelReset();
        m_state = 0; m_ret = 0; m_bola = 0; m_vidas = VIDAS_INICIAIS; m_pontos = 0;
        m_lost_seen = 0; m_unpaused = 0; m_tick = 0; m_rein = 0; m_pausa = 1;
        for (int i = 0; i < 2; i++) begin
            m_last[i] = 0; m_seen_low[i] = 0; m_pending[i] = 0;
        end
    endtask

    task automatic modelStep(input logic r, input logic [3:0] k, input logic bp, input logic bd);
        bit start, pse, lvl;
        int prev_pausa;
        int rein;
        if (r) begin
            modelReset();
            return;
        end
        start = m_pending[0];
        pse   = m_pending[1];
        for (int i = 0; i < 2; i++) begin
            lvl = k[2+i];
            m_pending[i]  = lvl && !m_last[i] && m_seen_low[i];
            m_seen_low[i] = m_seen_low[i] || !lvl;
            m_last[i]     = lvl;
        end
        prev_pausa = m_pausa;
        rein = 0;
        case (m_state)
            0, 5: if (start) begin
                m_state = 1; rein = 1; m_vidas = VIDAS_INICIAIS; m_pontos = 0; m_bola = 0;
            end
            1: if (pse) begin
                m_ret = 1; m_state = 3;
            end else if (start) begin
                m_state = 2; m_bola = 1;
            end
            2: begin
                if (bd) m_pontos = (m_pontos + 1) % 65536;
                if (bp) begin
                    m_state = 4; m_bola = 0;
                    m_vidas = (m_vidas > 0) ? m_vidas - 1 : 0;
                    m_lost_seen = 1;
                end else if (pse) begin
                    m_ret = 2; m_state = 3;
                end
            end
            3: if (pse) m_state = m_ret;
            4: if (m_lost_seen == LOST_CYCLES) m_state = (m_vidas == 0) ? 5 : 1;
               else m_lost_seen++;
            default: m_state = 0;
        endcase
        if (rein) begin
            m_unpaused = 0; m_tick = 0;
        end else if (prev_pausa == 0) begin
            m_unpaused++;
            m_tick = (m_unpaused % TICK_DIV == 0) ? 1 : 0;
        end else begin
            m_tick = 0;
        end
        m_rein  = rein;
        m_pausa = (m_state == 0 || m_state == 3 || m_state == 4 || m_state == 5) ? 1 : 0;
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] k, input logic bp, input logic bd);
        reset = r; keysout = k; bola_perdida = bp; bloco_destruido = bd;
        @(posedge CLOCK_50);
        modelStep(r, k, bp, bd);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkModel(input int cyc);
        checkOutput($sformatf("rand%0d.estado", cyc), estado, m_state);
        checkOutput($sformatf("rand%0d.pausa", cyc), pausa, m_pausa);
        checkOutput($sformatf("rand%0d.reiniciarJogo", cyc), reiniciarJogo, m_rein);
        checkOutput($sformatf("rand%0d.iniciarBola", cyc), iniciarBola, m_bola);
        checkOutput($sformatf("rand%0d.vidas", cyc), vidas, m_vidas);
        checkOutput($sformatf("rand%0d.pontos", cyc), pontos, m_pontos);
        checkOutput($sformatf("rand%0d.game_tick", cyc), game_tick, m_tick);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] keys;
        logic       bp;
        logic       bd;
        int         reps;
        int         e_estado;
        int         e_pausa;
        int         e_rein;
        int         e_bola;
        int         e_vidas;
        int         e_pontos;
    } vec_t;

    vec_t table_v[$];

    task automatic addVec(input logic r, input logic [3:0] k, input logic bp, input logic bd,
                          input int n, input int es, input int pa, input int re,
                          input int bo, input int vi, input int po);
        table_v.push_back('{r, k, bp, bd, n, es, pa, re, bo, vi, po});
    endtask

    task automatic expectTick(input string name, input int t);
        checkOutput(name, game_tick, t);
    endtask

    initial begin
        logic [3:0] k_lvl;
        logic       r_rnd, bp_rnd, bd_rnd;
        modelReset();

        // rst keys bp bd reps | estado pausa rein bola vidas pontos
        addVec(1, 4'h0, 0, 0, 1,  0, 1, 0, 0, 2, 0);
        addVec(0, 4'h0, 0, 0, 1,  0, 1, 0, 0, 2, 0);
        addVec(0, 4'h4, 0, 0, 1,  0, 1, 0, 0, 2, 0);
        addVec(0, 4'h4, 0, 0, 1,  1, 0, 1, 0, 2, 0);
        addVec(0, 4'h0, 0, 0, 1,  1, 0, 0, 0, 2, 0);
        addVec(0, 4'h0, 0, 1, 1,  1, 0, 0, 0, 2, 0);
        addVec(0, 4'h0, 1, 0, 1,  1, 0, 0, 0, 2, 0);
        addVec(0, 4'h4, 0, 0, 1,  1, 0, 0, 0, 2, 0);
        addVec(0, 4'h4, 0, 0, 1,  2, 0, 0, 1, 2, 0);
        addVec(0, 4'h0, 0, 1, 1,  2, 0, 0, 1, 2, 1);
        addVec(0, 4'h0, 0, 1, 1,  2, 0, 0, 1, 2, 2);
        addVec(0, 4'h0, 0, 0, 1,  2, 0, 0, 1, 2, 2);
        addVec(0, 4'h0, 0, 1, 1,  2, 0, 0, 1, 2, 3);
        addVec(0, 4'h8, 0, 0, 1,  2, 0, 0, 1, 2, 3);
        addVec(0, 4'h8, 0, 0, 1,  3, 1, 0, 1, 2, 3);
        addVec(0, 4'h0, 0, 1, 1,  3, 1, 0, 1, 2, 3);
        addVec(0, 4'h4, 0, 0, 2,  3, 1, 0, 1, 2, 3);
        addVec(0, 4'h0, 1, 0, 1,  3, 1, 0, 1, 2, 3);
        addVec(0, 4'h8, 0, 0, 1,  3, 1, 0, 1, 2, 3);
        addVec(0, 4'h8, 0, 0, 1,  2, 0, 0, 1, 2, 3);
        addVec(0, 4'h0, 0, 0, 1,  2, 0, 0, 1, 2, 3);
        addVec(0, 4'h8, 0, 0, 1,  2, 0, 0, 1, 2, 3);
        addVec(0, 4'h8, 1, 0, 1,  4, 1, 0, 0, 1, 3);
        addVec(0, 4'h0, 0, 0, 7,  4, 1, 0, 0, 1, 3);
        addVec(0, 4'h0, 0, 0, 1,  1, 0, 0, 0, 1, 3);
        addVec(0, 4'h4, 0, 0, 1,  1, 0, 0, 0, 1, 3);
        addVec(0, 4'h4, 0, 0, 1,  2, 0, 0, 1, 1, 3);
        addVec(0, 4'h0, 0, 1, 1,  2, 0, 0, 1, 1, 4);
        addVec(0, 4'h0, 1, 1, 1,  4, 1, 0, 0, 0, 5);
        addVec(0, 4'h0, 0, 0, 7,  4, 1, 0, 0, 0, 5);
        addVec(0, 4'h0, 0, 0, 1,  5, 1, 0, 0, 0, 5);
        addVec(0, 4'h0, 1, 1, 1,  5, 1, 0, 0, 0, 5);
        addVec(0, 4'h4, 0, 0, 1,  5, 1, 0, 0, 0, 5);
        addVec(0, 4'h4, 0, 0, 1,  1, 0, 1, 0, 2, 0);
        addVec(0, 4'h0, 0, 0, 1,  1, 0, 0, 0, 2, 0);
        addVec(0, 4'h4, 0, 0, 1,  1, 0, 0, 0, 2, 0);
        addVec(0, 4'h4, 0, 0, 1,  2, 0, 0, 1, 2, 0);
        addVec(0, 4'h0, 0, 1, 1,  2, 0, 0, 1, 2, 1);
        addVec(0, 4'h0, 0, 1, 1,  2, 0, 0, 1, 2, 2);
        addVec(0, 4'h0, 0, 1, 1,  2, 0, 0, 1, 2, 3);
        addVec(0, 4'h0, 0, 1, 1,  2, 0, 0, 1, 2, 4);
        addVec(0, 4'h0, 0, 1, 1,  2, 0, 0, 1, 2, 5);
        addVec(1, 4'h4, 0, 0, 1,  0, 1, 0, 0, 2, 0);
        addVec(0, 4'h4, 0, 0, 4,  0, 1, 0, 0, 2, 0);
        addVec(0, 4'h0, 0, 0, 1,  0, 1, 0, 0, 2, 0);
        addVec(0, 4'h4, 0, 0, 1,  0, 1, 0, 0, 2, 0);
        addVec(0, 4'h4, 0, 0, 1,  1, 0, 1, 0, 2, 0);

        foreach (table_v[i]) begin
            for (int n = 0; n < table_v[i].reps; n++) begin
                applyStimulus(table_v[i].rst, table_v[i].keys, table_v[i].bp, table_v[i].bd);
                checkOutput($sformatf("row%0d.estado", i), estado, table_v[i].e_estado);
                checkOutput($sformatf("row%0d.pausa", i), pausa, table_v[i].e_pausa);
                checkOutput($sformatf("row%0d.reiniciarJogo", i), reiniciarJogo, table_v[i].e_rein);
                checkOutput($sformatf("row%0d.iniciarBola", i), iniciarBola, table_v[i].e_bola);
                checkOutput($sformatf("row%0d.vidas", i), vidas, table_v[i].e_vidas);
                checkOutput($sformatf("row%0d.pontos", i), pontos, table_v[i].e_pontos);
            end
        end
        $display("[TB] vector table done");

        // Tick period after a restart, then phase retention across a pause.
        applyStimulus(1, 4'h0, 0, 0);
        applyStimulus(0, 4'h0, 0, 0);
        applyStimulus(0, 4'h4, 0, 0);
        applyStimulus(0, 4'h4, 0, 0);
        checkOutput("seq.restart_pulse", reiniciarJogo, 1);
        expectTick("seq.tick_at_restart", 0);
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(0, 4'h0, 0, 0);
            expectTick($sformatf("seq.tick%0d", i), (i % 4 == 0) ? 1 : 0);
        end
        applyStimulus(0, 4'h4, 0, 0);
        expectTick("seq.tick13", 0);
        applyStimulus(0, 4'h4, 0, 0);
        expectTick("seq.tick14", 0);
        checkOutput("seq.play", estado, 2);
        applyStimulus(0, 4'h0, 0, 0);
        expectTick("seq.tick15", 0);
        applyStimulus(0, 4'h0, 0, 0);
        expectTick("seq.tick16", 1);
        applyStimulus(0, 4'h0, 0, 0);
        expectTick("seq.tick17", 0);
        applyStimulus(0, 4'h8, 0, 0);
        expectTick("seq.tick18", 0);
        applyStimulus(0, 4'h8, 0, 0);
        expectTick("seq.tick19", 0);
        checkOutput("seq.paused", estado, 3);
        checkOutput("seq.bola_held", iniciarBola, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 4'h0, 0, 0);
            expectTick($sformatf("seq.paused_tick%0d", i), 0);
            checkOutput($sformatf("seq.paused_pausa%0d", i), pausa, 1);
        end
        applyStimulus(0, 4'h8, 0, 0);
        expectTick("seq.resume_a", 0);
        applyStimulus(0, 4'h8, 0, 0);
        expectTick("seq.resume_b", 0);
        checkOutput("seq.resumed", estado, 2);
        applyStimulus(0, 4'h0, 0, 0);
        expectTick("seq.phase_kept", 1);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 4'h0, 0, 0);
            expectTick($sformatf("seq.after_resume%0d", i), (i == 4) ? 1 : 0);
        end
        $display("[TB] tick/pause sequence done");

        // Randomized run against the reference model.
        k_lvl = 4'h0;
        applyStimulus(1, k_lvl, 0, 0);
        checkModel(0);
        for (int c = 1; c <= 3000; c++) begin
            if ($urandom_range(0, 7) == 0) k_lvl[2] = ~k_lvl[2];
            if ($urandom_range(0, 7) == 0) k_lvl[3] = ~k_lvl[3];
            k_lvl[1:0] = 2'($urandom_range(0, 3));
            r_rnd  = ($urandom_range(0, 399) == 0);
            bp_rnd = ($urandom_range(0, 15) == 0);
            bd_rnd = ($urandom_range(0, 3) == 0);
            applyStimulus(r_rnd, k_lvl, bp_rnd, bd_rnd);
            checkModel(c);
        end
        $display("[TB] random phase done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/controle_jogo.md
# controle_jogo

Game-level sequencer for the breakout-style game. It owns the game state machine (attract, serve, play, pause, life lost, game over) and drives the shared control lines consumed by the ship and ball blocks: `pausa`, `reiniciarJogo` and `iniciarBola`. It also generates the gated movement tick that paces ship and ball motion, and it keeps the lives and score counters. It sits between the debounced key block and the ship/ball/brick datapaths.

## Interface
- `TICK_DIV`, default 416667: period of `game_tick` in clock cycles (~120 Hz at 50 MHz); must be ≥2.
- `LOST_CYCLES`, default 50000000: cycles spent in LOST before the next serve or game over; must be ≥1.
- `VIDAS_INICIAIS`, default 3: lives loaded on game start; range 1..7.

- `CLOCK_50` input 1: system clock; the only clock.
- `reset` input 1: synchronous, active-high reset.
- `keysout` input 4: debounced key levels; bit2 = start/launch, bit3 = pause toggle; bits 1:0 are ignored here.
- `bola_perdida` input 1: ball left the bottom of the screen (level or pulse).
- `bloco_destruido` input 1: one-cycle pulse per brick hit.
- `pausa` output 1: movement freeze for the ship and ball.
- `reiniciarJogo` output 1: one-cycle restart pulse to the ship, ball and bricks.
- `iniciarBola` output 1: ball released (level).
- `game_tick` output 1: one-cycle movement enable.
- `vidas` output 3: lives remaining.
- `pontos` output 16: score.
- `estado` output 3: current state; IDLE=0, SERVE=1, PLAY=2, PAUSE=3, LOST=4, GAME_OVER=5.

## Operation
- All outputs are registered.
- Key events are rising edges of `keysout[2]` (start) and `keysout[3]` (pause). They come from an internal one-cycle-delayed copy of the keys. Holding a key produces exactly one event.
- State transitions:
  - IDLE or GAME_OVER, start event → SERVE. In the same transition: `reiniciarJogo`=1 for one cycle, `vidas`←VIDAS_INICIAIS, `pontos`←0, tick divider cleared.
  - SERVE, pause event → PAUSE (return state = SERVE). Otherwise start event → PLAY with `iniciarBola`←1. Pause has priority over start.
  - PLAY, `bola_perdida`=1 → LOST. In the same transition: `iniciarBola`←0, `vidas`←`vidas`−1 (saturating at 0), LOST counter cleared. `bola_perdida` has priority over a pause event in the same cycle.
  - PLAY, pause event (and no `bola_perdida`) → PAUSE (return state = PLAY).
  - PAUSE, pause event → the saved return state. `iniciarBola` is kept unchanged through the pause. Start events in PAUSE are ignored.
  - LOST: count cycles. After the LOST_CYCLES-th cycle in LOST: if `vidas`=0 → GAME_OVER, else → SERVE. Keys are ignored in LOST.
  - `bola_perdida` is ignored outside PLAY.
- `pausa` = 1 in IDLE, PAUSE, LOST and GAME_OVER; 0 in SERVE and PLAY. It is registered with the state, so it changes on the same edge as `estado`.
- Score:
  - `pontos` increments by 1 on each cycle with `bloco_destruido`=1 while `estado`=PLAY; it wraps from 0xFFFF to 0.
  - Pulses are ignored in every other state.
  - A pulse in the same cycle as a `bola_perdida` transition still counts.
- Tick divider:
  - Counts 0..TICK_DIV−1 only while the registered `pausa`=0; frozen (value held) while `pausa`=1.
  - `game_tick`=1 for one cycle on the cycle after the counter reaches TICK_DIV−1 while unpaused. The counter then returns to 0.
  - Cleared to 0 when `reiniciarJogo` is issued.

## Timing
- Reset values: `estado`=IDLE, `pausa`=1, `reiniciarJogo`=0, `iniciarBola`=0, `game_tick`=0, `vidas`=VIDAS_INICIAIS, `pontos`=0. The divider, LOST counter, return state and key history are all 0.
- Asserting reset mid-game returns to these values on the next edge, regardless of state. Reset has priority over every event.
- Key latency: a key rising at edge n (key level sampled at edge n) is reflected in `estado` and outputs after edge n+1.
- `bola_perdida`/`bloco_destruido` sampled at edge n are reflected after edge n (single-cycle registered response).
- LOST dwell is exactly LOST_CYCLES cycles: `estado`=LOST for LOST_CYCLES consecutive cycles.
- `game_tick` period is exactly TICK_DIV cycles of unpaused time. No tick is issued while `pausa`=1. A pause does not lose the accumulated count.

## Test plan
- Parameters for all scenarios: TICK_DIV=4, LOST_CYCLES=8, VIDAS_INICIAIS=2.
- Reset, then a start edge → one-cycle `reiniciarJogo`, `estado`=1, `pausa`=0, `vidas`=2, `pontos`=0. After that, `game_tick` pulses every 4 cycles.
- In SERVE, start edge → `estado`=2, `iniciarBola`=1. Three `bloco_destruido` pulses → `pontos`=3. A pulse while in SERVE or PAUSE leaves `pontos` unchanged.
- In PLAY, pause edge → `estado`=3, `pausa`=1, no `game_tick`, `iniciarBola` stays 1. Second pause edge → `estado`=2, and the tick phase continues where it stopped.
- In PLAY, `bola_perdida` and a pause edge in the same cycle → `estado`=4, `vidas`=1, `iniciarBola`=0. After exactly 8 cycles → `estado`=1.
- Lose the second life → `vidas`=0, LOST for 8 cycles, then `estado`=5. Start edge → `reiniciarJogo` pulse, `vidas`=2, `pontos`=0, `estado`=1.
- Assert reset while in PLAY with `pontos`=5 → next cycle `estado`=0, `pausa`=1, `pontos`=0, `iniciarBola`=0. Holding the start key high across reset release produces no start event until the key is released and pressed again.
